weight_fetch_scheduler: RTL and testbench
=========================================

// Module: weight_fetch_scheduler
// PURPOSE
//  Shares one single-port weight ROM (1-cycle read latency) among N_REQ layer/block weight loaders.
//  Round-robin arbitration picks one requester; the block bursts WORDS_PER_SET consecutive ROM words
//  from that requester's base address. Each word is returned with its index so the requester can latch
//  its 7-bit lanes (4 lanes/word). Sits between the per-block weight controllers and the weight ROM IP.
// PARAMETERS
//  N_REQ          4   number of requesters (>=2)
//  ADDR_W        10   ROM address width
//  DATA_W        28   ROM word width (4 x 7-bit weights)
//  WORDS_PER_SET  2   words per burst (>=1); fixed for all requesters
//  IDX_W          1   width of word index, = max(1,clog2(WORDS_PER_SET))
// PORTS
//  clk        in   1              single clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  req        in   N_REQ          level request per requester
//  base_addr  in   N_REQ*ADDR_W   start address per requester, slice i = [i*ADDR_W +: ADDR_W]
//  gnt        out  N_REQ          one-hot, 1-cycle pulse: burst accepted for requester i
//  rom_en     out  1              ROM read enable
//  rom_addr   out  ADDR_W         ROM read address
//  rom_dout   in   DATA_W         ROM data, valid 1 cycle after rom_en
//  wdata      out  DATA_W         registered ROM word
//  widx       out  IDX_W          word index of wdata within burst
//  wdst       out  N_REQ          one-hot owner of wdata, qualified by wvalid
//  wvalid     out  1              wdata/widx/wdst valid
//  done       out  N_REQ          one-hot, 1-cycle pulse with last wvalid of the burst
// BEHAVIOUR
//  - Reset: gnt, rom_en, rom_addr, wdata, widx, wdst, wvalid, done = 0; state IDLE; rr pointer = 0.
//  - All outputs registered. States: IDLE -> FETCH -> DRAIN -> IDLE.
//  - IDLE, cycle c, req!=0: grant lowest i >= ptr with req[i], else lowest i < ptr (wrap); ptr <= i+1 mod N_REQ.
//    c+1: gnt[i]=1, rom_en=1, rom_addr=base_addr[i] (captured at c; later base changes ignored).
//  - FETCH: rom_en=1 for K=WORDS_PER_SET consecutive cycles c+1..c+K, rom_addr = base+k, k=0..K-1,
//    addition modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0). Then DRAIN (rom_en=0) until last word out.
//  - Return: wvalid=1 in cycles c+3..c+K+2, widx=k, wdst=one-hot(i), wdata=rom_dout of address base+k.
//  - done[i]=1 in cycle c+K+2 (with last wvalid); state IDLE at c+K+3; next req sampled from c+K+3.
//    Minimum burst period K+3 cycles. K=1 legal: rom_en one cycle, wvalid/done at c+3.
//  - req is sampled only in IDLE; dropping req mid-burst does not abort. Requester must drop req by the
//    cycle after done, else it is treated as a new request (re-arbitrated with rotated pointer).
//  - Simultaneous requests: exactly one granted per burst; no requester starved (served within N_REQ bursts).
//  - Outside bursts wdata holds last value; widx/wdst/done/gnt/wvalid are 0.
//  - rst mid-burst: all outputs/state cleared next edge; in-flight words discarded, no done issued.
// STRUCTURE
//  - Package weight_sched_pkg: state encoding (IDLE/FETCH/DRAIN), default widths, clog2 helper.
//  - Sub-module rr_arbiter #(N): req, ptr -> one-hot grant + next ptr, purely combinational;
//    top holds ptr register, FSM, burst counter, address adder, 2-stage return pipeline (idx/dst/last).
// TESTING
//  - Reset: rst=1 2 cycles mid-burst -> all outputs 0 next cycle, no done, next grant goes to req[0].
//  - Single: req=0001, base0=0x010, K=2 -> gnt=0001 @c+1, rom_addr 0x010,0x011 @c+1,c+2,
//    wvalid widx 0,1 @c+3,c+4, done=0001 @c+4.
//  - Round-robin: req=1111 held -> grants 0001,0010,0100,1000,0001 every K+3=5 cycles.
//  - Wrap: base=0x3FF, K=2 -> rom_addr 0x3FF then 0x000; wdata matches ROM model for both.
//  - Late req/drop: req[2] rises during burst for [0] -> granted at first IDLE; req[0] dropped mid-burst ->
//    burst still completes with 2 words and done.
//  - K=1 build: back-to-back req=0011 -> gnt 0001 then 0010 four cycles apart, one wvalid each.

Source files
------------

// File: rtl/weight_sched_pkg.sv
// Shared types and helpers for the weight fetch scheduler.
package weight_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_N_REQ         = 4;
  localparam int DEF_ADDR_W        = 10;
  localparam int DEF_DATA_W        = 28;
  localparam int DEF_WORDS_PER_SET = 2;

  // Ceiling log2, never below 1 so a 1-entry range still gets a 1-bit field.
  function automatic int clog2_min1(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import weight_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);

  logic          found;
  logic [PW-1:0] idx;

  // Scan requesters in rotated order starting at ptr; next pointer is winner+1 mod N.
  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int off = 0; off < N; off++) begin
      idx = PW'((int'(ptr) + off) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_fetch_scheduler.sv
// Shares one single-port weight ROM among N_REQ loaders with round-robin bursts.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no burst; req sampled and arbitrated each cycle
// ST_FETCH | rom_en high, one ROM word issued per cycle (rom_en == FETCH)
// ST_DRAIN | issue finished, waiting for the last word to leave pipeline
module weight_fetch_scheduler
  import weight_sched_pkg::*;
#(
  parameter int N_REQ         = DEF_N_REQ,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int WORDS_PER_SET = DEF_WORDS_PER_SET,
  parameter int IDX_W         = clog2_min1(WORDS_PER_SET)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   base_addr,
  output logic [N_REQ-1:0]          gnt,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_dout,
  output logic [DATA_W-1:0]         wdata,
  output logic [IDX_W-1:0]          widx,
  output logic [N_REQ-1:0]          wdst,
  output logic                      wvalid,
  output logic [N_REQ-1:0]          done
);

  localparam int               PTR_W    = clog2_min1(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_SET - 1);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   own_q, own_d;
  logic [N_REQ-1:0]   gnt_d;
  logic               rom_en_d;
  logic [ADDR_W-1:0]  rom_addr_d;
  logic [N_REQ-1:0]   arb_gnt;
  logic [PTR_W-1:0]   arb_next_ptr;
  logic [ADDR_W-1:0]  sel_base;

  logic               s1_valid;
  logic               s1_last;
  logic [IDX_W-1:0]   s1_idx;
  logic [N_REQ-1:0]   s1_dst;

  rr_arbiter #(.N(N_REQ), .PW(PTR_W)) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .gnt      (arb_gnt),
    .next_ptr (arb_next_ptr)
  );

  // Pick the winning requester's base address; only consumed in IDLE.
  always_comb begin
    sel_base = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) sel_base = base_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Next-state and next-output logic; issue outputs are registered from these.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    own_d      = own_q;
    gnt_d      = '0;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d    = ST_FETCH;
          ptr_d      = arb_next_ptr;
          cnt_d      = '0;
          own_d      = arb_gnt;
          gnt_d      = arb_gnt;
          rom_en_d   = 1'b1;
          rom_addr_d = sel_base;
        end
      end
      ST_FETCH: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          rom_en_d   = 1'b1;
          rom_addr_d = rom_addr + 1'b1;
          cnt_d      = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (|done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, round-robin pointer and ROM issue registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      own_q    <= '0;
      gnt      <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      own_q    <= own_d;
      gnt      <= gnt_d;
      rom_en   <= rom_en_d;
      rom_addr <= rom_addr_d;
    end
  end

  // Two-stage return pipeline: tag travels alongside the ROM's one-cycle read.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
      s1_dst   <= '0;
      wdata    <= '0;
      widx     <= '0;
      wdst     <= '0;
      wvalid   <= 1'b0;
      done     <= '0;
    end else begin
      s1_valid <= rom_en;
      s1_last  <= (cnt_q == LAST_IDX);
      s1_idx   <= cnt_q;
      s1_dst   <= own_q;
      wvalid   <= s1_valid;
      widx     <= s1_valid ? s1_idx : '0;
      wdst     <= s1_valid ? s1_dst : '0;
      done     <= (s1_valid && s1_last) ? s1_dst : '0;
      if (s1_valid) wdata <= rom_dout;
    end
  end

endmodule

// File: tb/tb_weight_fetch_scheduler.sv
// Directed bench for weight_fetch_scheduler with a word scoreboard.
module tb_weight_fetch_scheduler;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 28;
  localparam int K  = 2;

  typedef struct {
    logic [N-1:0]  dst;
    logic [0:0]    idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] base_addr = '0;
  logic [N-1:0]    gnt;
  logic            rom_en;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_dout = '0;
  logic [DW-1:0]   wdata;
  logic [0:0]      widx;
  logic [N-1:0]    wdst;
  logic            wvalid;
  logic [N-1:0]    done;

  logic [N-1:0]    req1 = '0;
  logic [N*AW-1:0] base_addr1 = '0;
  logic [N-1:0]    gnt1;
  logic            rom_en1;
  logic [AW-1:0]   rom_addr1;
  logic [DW-1:0]   rom_dout1 = '0;
  logic [DW-1:0]   wdata1;
  logic [0:0]      widx1;
  logic [N-1:0]    wdst1;
  logic            wvalid1;
  logic [N-1:0]    done1;

  always #5 clk = ~clk;

  weight_fetch_scheduler #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_SET(K)) dut (
    .clk(clk), .rst(rst), .req(req), .base_addr(base_addr), .gnt(gnt),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout), .wdata(wdata),
    .widx(widx), .wdst(wdst), .wvalid(wvalid), .done(done)
  );

  weight_fetch_scheduler #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_SET(1)) dut_k1 (
    .clk(clk), .rst(rst), .req(req1), .base_addr(base_addr1), .gnt(gnt1),
    .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_dout(rom_dout1), .wdata(wdata1),
    .widx(widx1), .wdst(wdst1), .wvalid(wvalid1), .done(done1)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return {a, ~a, a[7:0]};
  endfunction

  // ROM models: one-cycle read latency.
  always @(posedge clk) begin
    if (rom_en)  rom_dout  <= rom_f(rom_addr);
    if (rom_en1) rom_dout1 <= rom_f(rom_addr1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_base(input int i, input logic [AW-1:0] v);
    base_addr[i*AW +: AW] = v;
  endtask

  function automatic logic [AW-1:0] get_base(input int i);
    return base_addr[i*AW +: AW];
  endfunction

  task automatic expect_burst(input int i, input logic [AW-1:0] b);
    exp_t e;
    for (int k = 0; k < K; k++) begin
      e.dst  = N'(1 << i);
      e.idx  = 1'(k);
      e.data = rom_f(b + AW'(k));
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor for the K=2 instance.
  always @(negedge clk) begin
    exp_t e;
    if (wvalid) begin
      if (sb.size() == 0) begin
        check("spurious_wvalid", 32'(wvalid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("wdst", 32'(wdst), 32'(e.dst));
        check("widx", 32'(widx), 32'(e.idx));
        check("wdata", 32'(wdata), 32'(e.data));
        check("done_with_word", 32'(done), (e.idx == 1'(K - 1)) ? 32'(e.dst) : 32'd0);
      end
    end else begin
      check("idle_done", 32'(done), 32'd0);
      check("idle_wdst", 32'(wdst), 32'd0);
    end
  end

  initial begin
    set_base(0, 10'h010);
    set_base(1, 10'h123);
    set_base(2, 10'h3FF);
    set_base(3, 10'h200);
    base_addr1[0*AW +: AW] = 10'h2A0;
    base_addr1[1*AW +: AW] = 10'h055;

    // Reset values
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rom_en", 32'(rom_en), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_widx", 32'(widx), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    rst = 1'b0;

    // Single burst for requester 0
    tick();
    req = 4'b0001;
    expect_burst(0, 10'h010);
    tick();
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_en0", 32'(rom_en), 32'd1);
    check("single_addr0", 32'(rom_addr), 32'h010);
    req = 4'b0000;
    tick();
    check("single_gnt_pulse", 32'(gnt), 32'd0);
    check("single_en1", 32'(rom_en), 32'd1);
    check("single_addr1", 32'(rom_addr), 32'h011);
    tick();
    check("single_en_off", 32'(rom_en), 32'd0);
    check("single_wvalid0", 32'(wvalid), 32'd1);
    check("single_done_early", 32'(done), 32'd0);
    tick();
    check("single_wvalid1", 32'(wvalid), 32'd1);
    check("single_done", 32'(done), 32'h1);
    tick();
    check("single_after", 32'(wvalid), 32'd0);

    // Reset mid-burst: pointer is 1, requester 2 granted, then rst for 2 cycles
    req = 4'b0100;
    tick();
    check("rstmid_gnt", 32'(gnt), 32'h4);
    rst = 1'b1;
    req = 4'b0000;
    tick();
    check("rstmid_gnt0", 32'(gnt), 32'd0);
    check("rstmid_en0", 32'(rom_en), 32'd0);
    check("rstmid_addr0", 32'(rom_addr), 32'd0);
    check("rstmid_wdata0", 32'(wdata), 32'd0);
    check("rstmid_wvalid0", 32'(wvalid), 32'd0);
    tick();
    rst = 1'b0;

    // Round robin with all requesting; pointer back at 0 after reset
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      expect_burst(b % N, get_base(b % N));
      tick();
      check("rr_gnt", 32'(gnt), 32'(1 << (b % N)));
      check("rr_addr0", 32'(rom_addr), 32'(get_base(b % N)));
      tick();
      check("rr_addr1", 32'(rom_addr), 32'(AW'(get_base(b % N) + 10'd1)));
      repeat (3) tick();
    end
    req = 4'b0000;

    // Late request and mid-burst drop; pointer is 1, only requester 0 asks
    req = 4'b0001;
    expect_burst(0, 10'h010);
    tick();
    check("late_gnt0", 32'(gnt), 32'h1);
    req = 4'b0100;
    repeat (3) tick();
    check("late_done0", 32'(done), 32'h1);
    tick();
    expect_burst(2, 10'h3FF);
    tick();
    check("late_gnt2", 32'(gnt), 32'h4);
    req = 4'b0000;
    repeat (6) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    // K=1 instance: back-to-back requests from 0 and 1
    req1 = 4'b0011;
    tick();
    check("k1_gnt0", 32'(gnt1), 32'h1);
    check("k1_addr0", 32'(rom_addr1), 32'h2A0);
    tick();
    check("k1_en_off", 32'(rom_en1), 32'd0);
    check("k1_gnt_pulse", 32'(gnt1), 32'd0);
    tick();
    check("k1_wvalid0", 32'(wvalid1), 32'd1);
    check("k1_wdst0", 32'(wdst1), 32'h1);
    check("k1_done0", 32'(done1), 32'h1);
    check("k1_wdata0", 32'(wdata1), 32'(rom_f(10'h2A0)));
    tick();
    check("k1_gap_wvalid", 32'(wvalid1), 32'd0);
    check("k1_gap_gnt", 32'(gnt1), 32'd0);
    tick();
    check("k1_gnt1", 32'(gnt1), 32'h2);
    check("k1_addr1", 32'(rom_addr1), 32'h055);
    req1 = 4'b0000;
    repeat (2) tick();
    check("k1_wvalid1", 32'(wvalid1), 32'd1);
    check("k1_done1", 32'(done1), 32'h2);
    check("k1_wdata1", 32'(wdata1), 32'(rom_f(10'h055)));
    tick();
    check("k1_end_wvalid", 32'(wvalid1), 32'd0);
    check("k1_hold_wdata", 32'(wdata1), 32'(rom_f(10'h055)));

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
